// File: rtl/weights_stream_pkg.sv
// -----------------------------------------------------------------------------
// weights_stream_pkg
// Shared types for the convolution weight streamer:
//   state_t         - streamer FSM states
//   beat_t          - one output beat (weight plus framing flags) as it sits in
//                     the skid buffer
//   wpf()           - weights per filter for a given channel count / kernel size
//   BEAT_DATA_WIDTH - weight width carried by beat_t
// -----------------------------------------------------------------------------
package weights_stream_pkg;

  // beat_t is a packed struct, so its weight field needs a fixed width. The
  // streamer's DATA_WIDTH defaults to this value and must match it.
  localparam int BEAT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [BEAT_DATA_WIDTH-1:0] data;
    logic                              last_ch;  // last element of a K x K window
    logic                              last;     // last weight of a filter
  } beat_t;

  // Weights per filter: every input channel carries a full K x K kernel.
  function automatic int wpf(input int in_channels, input int kernel_size);
    return in_channels * kernel_size * kernel_size;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// -----------------------------------------------------------------------------
// stream_skid_buffer
// Two-entry FIFO of beat_t sitting between the weight memory read port and the
// valid/ready output. The producer only pushes when it holds a credit, so the
// buffer never overflows. Pushes and pops in the same cycle are allowed.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_beat this cycle
//   push_beat   - beat to store
//   pop         - discard the head entry this cycle
//   head        - oldest stored entry (meaningful when occupancy != 0)
//   occupancy   - number of stored entries, 0..2
// -----------------------------------------------------------------------------
module stream_skid_buffer
  import weights_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] occupancy
);

  beat_t      entry_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push_ok;
  logic       pop_ok;

  // Protect the storage even if a caller misbehaves: no push into a full
  // buffer unless the head leaves in the same cycle, no pop from empty.
  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset as well, so the head (and wr_data) reads 0
      // out of reset instead of X, and nothing from before a reset survives.
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        entry_q[wr_ptr_q] <= push_beat;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head      = entry_q[rd_ptr_q];
  assign occupancy = count_q;

endmodule

// File: rtl/weights_streamer.sv
// -----------------------------------------------------------------------------
// weights_streamer
// Producer side of the convolution weights FIFO. On start it reads
// filter_count filters beginning at filter_start from a synchronous weight
// memory (1-cycle read latency) and emits them as a valid/ready stream, one
// weight per beat, ordered filter -> input channel -> kernel element
// (row-major). Filter indices wrap modulo NUM_FILTERS.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   start          - command strobe, only honoured while idle
//   filter_start   - first filter index (latched on start)
//   filter_count   - filters to send, 0..NUM_FILTERS (latched on start)
//   busy           - command in progress
//   done           - one-cycle pulse when the command completes
//   mem_rd_en      - weight memory read enable
//   mem_addr       - weight memory read address
//   mem_rd_data    - read data, valid the cycle after mem_rd_en
//   wr_valid       - output beat valid
//   wr_ready       - downstream accepts the beat
//   wr_data        - weight
//   wr_last_ch     - beat closes a channel's K x K window
//   wr_last        - beat closes a filter
// -----------------------------------------------------------------------------
module weights_streamer
  import weights_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = BEAT_DATA_WIDTH,
  parameter int IN_CHANNELS = 4,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_FILTERS = 8,
  parameter int ADDR_WIDTH  = $clog2(NUM_FILTERS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(NUM_FILTERS)-1:0] filter_start,
  input  logic [$clog2(NUM_FILTERS):0]   filter_count,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic signed [DATA_WIDTH-1:0] mem_rd_data,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic signed [DATA_WIDTH-1:0] wr_data,
  output logic                         wr_last_ch,
  output logic                         wr_last
);

  localparam int WPF         = wpf(IN_CHANNELS, KERNEL_SIZE);
  localparam int K2          = KERNEL_SIZE * KERNEL_SIZE;
  localparam int TOTAL_WORDS = NUM_FILTERS * WPF;
  localparam int FCW         = $clog2(NUM_FILTERS) + 1;
  localparam int EW          = (K2 > 1) ? $clog2(K2) : 1;
  localparam int CW          = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_WORDS - 1);

  state_t state_q;
  state_t state_d;

  // Command and issue-side counters. Framing flags are derived here, at read
  // issue, and travel with the data through the buffer.
  logic [FCW-1:0]        count_q;
  logic [FCW-1:0]        filt_q;
  logic [CW-1:0]         chan_q;
  logic [EW-1:0]         elem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  issue_done_q;

  // One read in flight at most per cycle (memory latency is one cycle).
  logic rd_pend_q;
  logic pend_last_ch_q;
  logic pend_last_q;

  logic       elem_last;
  logic       chan_last;
  logic       filt_last;
  logic       pop;
  logic       issue;
  logic       stream_end;
  logic [2:0] outstanding;
  logic [1:0] occupancy;
  beat_t      push_beat;
  beat_t      head;

  assign elem_last = (elem_q == EW'(K2 - 1));
  assign chan_last = (chan_q == CW'(IN_CHANNELS - 1));
  assign filt_last = ((filt_q + FCW'(1)) == count_q);

  assign wr_valid = (occupancy != 2'd0);
  assign pop      = wr_valid && wr_ready;

  // Credit: buffered entries plus the read in flight, less the entry leaving
  // this cycle, must leave room for one more read's data.
  assign outstanding = {1'b0, occupancy} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue       = (state_q == STREAM) && !issue_done_q && (outstanding < 3'd2);

  // The command ends once every read has been issued and returned and the
  // last buffered entry is being accepted (or the buffer is already empty).
  assign stream_end = issue_done_q && !rd_pend_q &&
                      ((occupancy == 2'd0) || ((occupancy == 2'd1) && pop));

  assign mem_rd_en = issue;
  assign mem_addr  = addr_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (filter_count == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        busy = 1'b1;
        if (stream_end) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q        <= '0;
      filt_q         <= '0;
      chan_q         <= '0;
      elem_q         <= '0;
      addr_q         <= '0;
      issue_done_q   <= 1'b0;
      rd_pend_q      <= 1'b0;
      pend_last_ch_q <= 1'b0;
      pend_last_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every counter update
      // below sees the pre-edge values of the others.
      rd_pend_q      <= issue;
      pend_last_ch_q <= elem_last;
      pend_last_q    <= elem_last && chan_last;

      if ((state_q == IDLE) && start) begin
        count_q      <= filter_count;
        filt_q       <= '0;
        chan_q       <= '0;
        elem_q       <= '0;
        addr_q       <= ADDR_WIDTH'(filter_start) * ADDR_WIDTH'(WPF);
        issue_done_q <= 1'b0;
      end else if (issue) begin
        // Filters are stored back to back, so wrapping the flat address
        // fetches filters modulo NUM_FILTERS.
        addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
        if (elem_last) begin
          elem_q <= '0;
          if (chan_last) begin
            chan_q <= '0;
            filt_q <= filt_q + FCW'(1);
            if (filt_last) begin
              issue_done_q <= 1'b1;
            end
          end else begin
            chan_q <= chan_q + CW'(1);
          end
        end else begin
          elem_q <= elem_q + EW'(1);
        end
      end
    end
  end

  always_comb begin
    push_beat         = '0;
    push_beat.data    = mem_rd_data;
    push_beat.last_ch = pend_last_ch_q;
    push_beat.last    = pend_last_q;
  end

  stream_skid_buffer u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend_q),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .occupancy (occupancy)
  );

  assign wr_data    = head.data;
  assign wr_last_ch = head.last_ch;
  assign wr_last    = head.last;

endmodule
